// File: rtl/instr_exec_responder_pkg.sv
// Shared widths, instruction layout, opcode constants and FSM encoding
// for the instruction execute responder.
package instr_exec_responder_pkg;

    localparam int NUMBER_OF_PC_REGISTERS = 256;
    localparam int PC_WIDTH               = $clog2(NUMBER_OF_PC_REGISTERS);
    localparam int OPERATION_TYPE_WIDTH   = 2;
    localparam int OPCODE_WIDTH           = 3;
    localparam int NUMBER_OF_REGISTERS    = 16;
    localparam int ADDR_WIDTH             = $clog2(NUMBER_OF_REGISTERS);
    localparam int WORD_SIZE              = 16;
    localparam int INSTR_WIDTH            = OPERATION_TYPE_WIDTH + OPCODE_WIDTH
                                          + 3 * ADDR_WIDTH + PC_WIDTH + WORD_SIZE;

    // Field LSB positions, MSB-first layout: optype opcode rd rs1 rs2 target imm
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = IMM_LSB + WORD_SIZE;
    localparam int RS2_LSB    = TARGET_LSB + PC_WIDTH;
    localparam int RS1_LSB    = RS2_LSB + ADDR_WIDTH;
    localparam int RD_LSB     = RS1_LSB + ADDR_WIDTH;
    localparam int OPCODE_LSB = RD_LSB + ADDR_WIDTH;
    localparam int OPTYPE_LSB = OPCODE_LSB + OPCODE_WIDTH;

    typedef enum logic [OPERATION_TYPE_WIDTH-1:0] {
        OPT_REG = 2'd0,
        OPT_IMM = 2'd1,
        OPT_BR  = 2'd2,
        OPT_SYS = 2'd3
    } optype_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 3'd0, OP_SUB  = 3'd1, OP_AND  = 3'd2,
                                        OP_OR   = 3'd3, OP_XOR  = 3'd4, OP_SLL  = 3'd5,
                                        OP_SRL  = 3'd6, OP_SLT  = 3'd7;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 3'd0, OP_LOADI = 3'd1, OP_ANDI = 3'd2,
                                        OP_ORI  = 3'd3, OP_XORI  = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 3'd0, OP_BEQ  = 3'd1, OP_BNE  = 3'd2,
                                        OP_BLT  = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 3'd0, OP_HALT = 3'd1;

    typedef struct packed {
        optype_e                   optype;
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [ADDR_WIDTH-1:0]     rd;
        logic [ADDR_WIDTH-1:0]     rs1;
        logic [ADDR_WIDTH-1:0]     rs2;
        logic [PC_WIDTH-1:0]       target;
        logic [WORD_SIZE-1:0]      imm;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_COMPLETE  = 3'd4
    } state_e;

endpackage

// File: rtl/instr_exec_responder_exec_regfile.sv
// Register file: R0 hardwired to zero, two operand read ports plus a debug
// read port, one synchronous write port, synchronous clear.
module exec_regfile
    import instr_exec_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_SIZE-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    input  logic [ADDR_WIDTH-1:0] dbg_raddr,
    output logic [WORD_SIZE-1:0]  rdata_a,
    output logic [WORD_SIZE-1:0]  rdata_b,
    output logic [WORD_SIZE-1:0]  dbg_rdata
);

    logic [WORD_SIZE-1:0] mem [NUMBER_OF_REGISTERS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a   == '0) ? '0 : mem[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : mem[raddr_b];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem[dbg_raddr];

endmodule

// File: rtl/instr_exec_responder.sv
// Responder side of the CPU fetch handshake: accepts one instruction per
// start, runs it through decode/execute/writeback and returns the next PC.
module instr_exec_responder
    import instr_exec_responder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   busy,
    output logic                   done,
    output logic                   fetch_stage_enable,
    output logic [PC_WIDTH-1:0]    next_pc_to_cpu,
    output logic                   halted,
    output logic                   illegal_instr,
    input  logic [ADDR_WIDTH-1:0]  dbg_raddr,
    output logic [WORD_SIZE-1:0]   dbg_rdata
);

    state_e               state, state_n;
    instr_t               instr_q;
    logic [WORD_SIZE-1:0] op_a, op_b, rs1_data, rs2_data, result_q, alu_res;
    logic [PC_WIDTH-1:0]  pc_reg, new_pc_q, pc_next;
    logic                 wr_q, halt_q, illegal_q;
    logic                 alu_wr, taken, is_halt, is_illegal;
    logic                 accept;

    assign accept = (state == S_IDLE) && start && !halted;

    exec_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        ((state == S_WRITEBACK) && wr_q),
        .waddr     (instr_q.rd),
        .wdata     (result_q),
        .raddr_a   (instr_q.rs1),
        .raddr_b   (instr_q.rs2),
        .dbg_raddr (dbg_raddr),
        .rdata_a   (rs1_data),
        .rdata_b   (rs2_data),
        .dbg_rdata (dbg_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE:      if (accept) state_n = S_DECODE;
            S_DECODE:    begin busy = 1'b1; state_n = S_EXECUTE;   end
            S_EXECUTE:   begin busy = 1'b1; state_n = S_WRITEBACK; end
            S_WRITEBACK: begin busy = 1'b1; state_n = S_COMPLETE;  end
            S_COMPLETE:  begin done = 1'b1; state_n = S_IDLE;      end
            default:     state_n = S_IDLE;
        endcase
    end

    // Undefined encodings fall through as a NOP with the illegal flag raised.
    always_comb begin
        alu_res    = '0;
        alu_wr     = 1'b0;
        taken      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (instr_q.optype)
            OPT_REG: begin
                alu_wr = 1'b1;
                case (instr_q.opcode)
                    OP_ADD:  alu_res = op_a + op_b;
                    OP_SUB:  alu_res = op_a - op_b;
                    OP_AND:  alu_res = op_a & op_b;
                    OP_OR:   alu_res = op_a | op_b;
                    OP_XOR:  alu_res = op_a ^ op_b;
                    OP_SLL:  alu_res = op_a << op_b[3:0];
                    OP_SRL:  alu_res = op_a >> op_b[3:0];
                    default: alu_res = {{(WORD_SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                endcase
            end
            OPT_IMM: begin
                alu_wr = 1'b1;
                case (instr_q.opcode)
                    OP_ADDI:  alu_res = op_a + instr_q.imm;
                    OP_LOADI: alu_res = instr_q.imm;
                    OP_ANDI:  alu_res = op_a & instr_q.imm;
                    OP_ORI:   alu_res = op_a | instr_q.imm;
                    OP_XORI:  alu_res = op_a ^ instr_q.imm;
                    default:  begin alu_wr = 1'b0; is_illegal = 1'b1; end
                endcase
            end
            OPT_BR: begin
                case (instr_q.opcode)
                    OP_JMP:  taken = 1'b1;
                    OP_BEQ:  taken = (op_a == op_b);
                    OP_BNE:  taken = (op_a != op_b);
                    OP_BLT:  taken = ($signed(op_a) < $signed(op_b));
                    default: is_illegal = 1'b1;
                endcase
            end
            default: begin
                case (instr_q.opcode)
                    OP_NOP:  ;
                    OP_HALT: is_halt = 1'b1;
                    default: is_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign pc_next = is_halt ? pc_reg :
                     taken   ? instr_q.target : pc_reg + PC_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q            <= '0;
            op_a               <= '0;
            op_b               <= '0;
            result_q           <= '0;
            wr_q               <= 1'b0;
            halt_q             <= 1'b0;
            illegal_q          <= 1'b0;
            new_pc_q           <= '0;
            pc_reg             <= '0;
            next_pc_to_cpu     <= '0;
            fetch_stage_enable <= 1'b0;
            halted             <= 1'b0;
            illegal_instr      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    instr_q            <= instr_t'(instruction);
                    fetch_stage_enable <= 1'b0;
                end
                S_DECODE: begin
                    op_a <= rs1_data;
                    op_b <= rs2_data;
                end
                S_EXECUTE: begin
                    result_q  <= alu_res;
                    wr_q      <= alu_wr;
                    new_pc_q  <= pc_next;
                    halt_q    <= is_halt;
                    illegal_q <= is_illegal;
                end
                S_WRITEBACK: begin
                    pc_reg             <= new_pc_q;
                    next_pc_to_cpu     <= new_pc_q;
                    fetch_stage_enable <= !halt_q;
                    halted             <= halted | halt_q;
                    illegal_instr      <= illegal_instr | illegal_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_responder.sv
// Directed table-driven bench for instr_exec_responder plus hand-written
// reset and halt sequences.
module tb_instr_exec_responder;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [40:0] instruction;
    logic        busy, done, fetch_stage_enable, halted, illegal_instr;
    logic [7:0]  next_pc_to_cpu;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    instr_exec_responder dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .instruction        (instruction),
        .busy               (busy),
        .done               (done),
        .fetch_stage_enable (fetch_stage_enable),
        .next_pc_to_cpu     (next_pc_to_cpu),
        .halted             (halted),
        .illegal_instr      (illegal_instr),
        .dbg_raddr          (dbg_raddr),
        .dbg_rdata          (dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [40:0] ins;
        int          hold;
        logic [3:0]  dbg;
        logic [15:0] rdata;
        logic [7:0]  npc;
        logic        exec;
        logic        fse;
        logic        ill;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] mk(input logic [1:0] ot, input logic [2:0] oc,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2, input logic [7:0] tg,
                                       input logic [15:0] imm);
        return {ot, oc, rd, rs1, rs2, tg, imm};
    endfunction

    function automatic void add(input logic [40:0] ins, input int hold, input logic [3:0] dbg,
                                input logic [15:0] rdata, input logic [7:0] npc, input logic exec,
                                input logic fse, input logic ill, input logic hlt);
        vec_t v;
        v.ins = ins; v.hold = hold; v.dbg = dbg; v.rdata = rdata; v.npc = npc;
        v.exec = exec; v.fse = fse; v.ill = ill; v.hlt = hlt;
        vecs.push_back(v);
    endfunction

    // Drive start on a negedge, hold it `hold` cycles past busy rising,
    // then count busy and done cycles over a fixed 7-cycle window.
    task automatic run(input logic [40:0] ins, input int hold, output int nb, output int nd);
        @(negedge clk);
        instruction = ins;
        start = 1'b1;
        nb = 0;
        nd = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
            if (c > hold) start = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int nb, nd;
        rst = 1'b1; start = 1'b0; instruction = '0; dbg_raddr = '0;

        // optype: 0 reg, 1 imm, 2 branch, 3 system
        add(mk(1,1,1,0,0,0,16'h1234), 2, 1, 16'h1234, 8'h01, 1, 1, 0, 0); // LOADI R1
        add(mk(1,1,1,0,0,0,16'h0005), 0, 1, 16'h0005, 8'h02, 1, 1, 0, 0); // LOADI R1,5
        add(mk(1,1,2,0,0,0,16'h0007), 0, 2, 16'h0007, 8'h03, 1, 1, 0, 0); // LOADI R2,7
        add(mk(0,0,3,1,2,0,16'h0),    0, 3, 16'h000C, 8'h04, 1, 1, 0, 0); // ADD
        add(mk(0,1,4,1,2,0,16'h0),    0, 4, 16'hFFFE, 8'h05, 1, 1, 0, 0); // SUB
        add(mk(0,2,5,3,2,0,16'h0),    0, 5, 16'h0004, 8'h06, 1, 1, 0, 0); // AND
        add(mk(0,5,6,1,2,0,16'h0),    0, 6, 16'h0280, 8'h07, 1, 1, 0, 0); // SLL 5<<7
        add(mk(0,7,7,4,1,0,16'h0),    0, 7, 16'h0001, 8'h08, 1, 1, 0, 0); // SLT -2<5
        add(mk(0,6,9,4,2,0,16'h0),    0, 9, 16'h01FF, 8'h09, 1, 1, 0, 0); // SRL
        add(mk(0,3,10,3,6,0,16'h0),   0, 10,16'h028C, 8'h0A, 1, 1, 0, 0); // OR
        add(mk(0,4,11,3,2,0,16'h0),   0, 11,16'h000B, 8'h0B, 1, 1, 0, 0); // XOR
        add(mk(1,0,12,3,0,0,16'hFFFF),0, 12,16'h000B, 8'h0C, 1, 1, 0, 0); // ADDI -1
        add(mk(1,2,13,4,0,0,16'h0F0F),0, 13,16'h0F0E, 8'h0D, 1, 1, 0, 0); // ANDI
        add(mk(1,3,14,5,0,0,16'h1000),0, 14,16'h1004, 8'h0E, 1, 1, 0, 0); // ORI
        add(mk(1,1,1,0,0,0,16'h0003), 0, 1, 16'h0003, 8'h0F, 1, 1, 0, 0); // LOADI R1,3
        add(mk(1,1,2,0,0,0,16'h0003), 0, 2, 16'h0003, 8'h10, 1, 1, 0, 0); // LOADI R2,3
        add(mk(2,1,0,1,2,8'h40,16'h0),0, 1, 16'h0003, 8'h40, 1, 1, 0, 0); // BEQ taken
        add(mk(2,2,0,1,2,8'h80,16'h0),0, 2, 16'h0003, 8'h41, 1, 1, 0, 0); // BNE not taken
        add(mk(1,1,1,0,0,0,16'hFFFF), 0, 1, 16'hFFFF, 8'h42, 1, 1, 0, 0); // LOADI R1,-1
        add(mk(1,1,2,0,0,0,16'h0001), 0, 2, 16'h0001, 8'h43, 1, 1, 0, 0); // LOADI R2,1
        add(mk(2,3,0,1,2,8'h20,16'h0),0, 1, 16'hFFFF, 8'h20, 1, 1, 0, 0); // BLT taken
        add(mk(1,4,8,1,0,0,16'h00FF), 0, 8, 16'hFF00, 8'h21, 1, 1, 0, 0); // XORI
        add(mk(1,6,9,1,0,0,16'h5555), 0, 9, 16'h01FF, 8'h22, 1, 1, 1, 0); // illegal imm op6
        add(mk(0,0,0,1,1,0,16'h0),    0, 0, 16'h0000, 8'h23, 1, 1, 1, 0); // ADD R0 dropped
        add(mk(2,0,0,0,0,8'hFF,16'h0),0, 1, 16'hFFFF, 8'hFF, 1, 1, 1, 0); // JMP 255
        add(mk(3,0,0,0,0,0,16'h0),    0, 2, 16'h0001, 8'h00, 1, 1, 1, 0); // NOP wraps
        add(mk(3,1,0,0,0,0,16'h0),    0, 8, 16'hFF00, 8'h00, 1, 0, 1, 1); // HALT
        add(mk(1,1,1,0,0,0,16'h0009), 1, 1, 16'hFFFF, 8'h00, 0, 0, 1, 1); // ignored

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fse", fetch_stage_enable, 0);
        chk("rst_npc", next_pc_to_cpu, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal_instr, 0);

        foreach (vecs[i]) begin
            run(vecs[i].ins, vecs[i].hold, nb, nd);
            dbg_raddr = vecs[i].dbg;
            #1;
            chk($sformatf("v%0d_busy_cycles", i), nb, vecs[i].exec ? 3 : 0);
            chk($sformatf("v%0d_done_cycles", i), nd, vecs[i].exec ? 1 : 0);
            chk($sformatf("v%0d_npc", i), next_pc_to_cpu, vecs[i].npc);
            chk($sformatf("v%0d_rdata", i), dbg_rdata, vecs[i].rdata);
            chk($sformatf("v%0d_fse", i), fetch_stage_enable, vecs[i].fse);
            chk($sformatf("v%0d_illegal", i), illegal_instr, vecs[i].ill);
            chk($sformatf("v%0d_halted", i), halted, vecs[i].hlt);
        end

        // Reset clears halt; then abort an instruction in EXECUTE.
        do_reset();
        chk("rst2_halted", halted, 0);
        run(mk(1,1,3,0,0,0,16'h0077), 0, nb, nd);
        chk("pre_abort_npc", next_pc_to_cpu, 8'h01);
        @(negedge clk);
        instruction = mk(1,1,3,0,0,0,16'h0099);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_execute_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dbg_raddr = 4'd3;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_npc", next_pc_to_cpu, 0);
        chk("abort_r3", dbg_rdata, 16'h0000);
        nb = 0; nd = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        chk("abort_no_busy", nb, 0);
        chk("abort_no_done", nd, 0);
        run(mk(1,1,2,0,0,0,16'h0011), 0, nb, nd);
        dbg_raddr = 4'd2;
        #1;
        chk("post_abort_npc", next_pc_to_cpu, 8'h01);
        chk("post_abort_r2", dbg_rdata, 16'h0011);
        chk("post_abort_done", nd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
